reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 124 ++++++++++++
 tb/tb_reg_dump_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks addresses FIRST_ADDR..LAST_ADDR, captures each
// 128-bit register in one cycle and streams it out as 32-bit words over valid/ready.
module reg_dump_reader #(
    parameter logic [4:0] FIRST_ADDR = 5'd1,
    parameter logic [4:0] LAST_ADDR  = 5'd31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [4:0]   rf_addr,
    input  logic [127:0] rf_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [6:0]   out_tag,
    output logic         out_last
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [4:0]     counter;
    logic [1:0]     lane;
    logic [127:0]   capture;
    logic           final_word;
    logic           at_last;
    logic           xfer;
    logic [31:0]    lane_word;

    // Vector registers (addr[4:3]==2'b11) emit four lanes, scalars only lane 0.
    assign final_word = (counter[4:3] == 2'b11) ? (lane == 2'd3) : (lane == 2'd0);
    assign at_last    = (counter == LAST_ADDR);
    assign xfer       = (state == SEND) && out_ready;

    always_comb begin
        lane_word = capture[31:0];
        case (lane)
            2'd0: lane_word = capture[31:0];
            2'd1: lane_word = capture[63:32];
            2'd2: lane_word = capture[95:64];
            2'd3: lane_word = capture[127:96];
            default: lane_word = capture[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            lane    <= '0;
            capture <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= FIRST_ADDR;
                    end
                end
                READ: begin
                    capture <= rf_data;
                    lane    <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        if (!final_word) begin
                            lane <= lane + 2'd1;
                        end else if (!at_last) begin
                            counter <= counter + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        rf_addr   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_tag   = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                rf_addr  = counter;
                state_nx = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = lane_word;
                out_tag   = {counter, lane};
                out_last  = final_word && at_last;
                if (xfer && final_word) begin
                    state_nx = at_last ? DONE : READ;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: default-range instance plus a single-register
// (31..31) instance, sharing a behavioural register file.
module tb_reg_dump_reader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start1 = 1'b0;
    logic         start2 = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] rf [0:31];

    logic         busy1, done1, valid1, last1;
    logic [4:0]   rf_addr1;
    logic [127:0] rf_data1;
    logic [31:0]  data1;
    logic [6:0]   tag1;
    logic         busy2, done2, valid2, last2;
    logic [4:0]   rf_addr2;
    logic [127:0] rf_data2;
    logic [31:0]  data2;
    logic [6:0]   tag2;

    int tests = 0;
    int fails = 0;

    logic [31:0] obs_d [0:63];
    logic [6:0]  obs_t [0:63];
    int          n_obs;

    bit          cur_sel = 1'b0;
    logic        v, bz, dn, lst;
    logic [31:0] d;
    logic [6:0]  t;
    logic [4:0]  ra;

    always #5 clk = ~clk;

    assign rf_data1 = rf[rf_addr1];
    assign rf_data2 = rf[rf_addr2];

    reg_dump_reader dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rf_addr(rf_addr1), .rf_data(rf_data1), .out_valid(valid1), .out_ready(out_ready),
        .out_data(data1), .out_tag(tag1), .out_last(last1)
    );

    reg_dump_reader #(.FIRST_ADDR(5'd31), .LAST_ADDR(5'd31)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rf_addr(rf_addr2), .rf_data(rf_data2), .out_valid(valid2), .out_ready(out_ready),
        .out_data(data2), .out_tag(tag2), .out_last(last2)
    );

    always_comb begin
        v   = cur_sel ? valid2   : valid1;
        bz  = cur_sel ? busy2    : busy1;
        dn  = cur_sel ? done2    : done1;
        lst = cur_sel ? last2    : last1;
        d   = cur_sel ? data2    : data1;
        t   = cur_sel ? tag2     : tag1;
        ra  = cur_sel ? rf_addr2 : rf_addr1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] observed, input logic [127:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    function automatic logic [31:0] init_word(input int a, input int l);
        logic [4:0] a5;
        logic [1:0] l2;
        a5 = a[4:0];
        l2 = l[1:0];
        return {3'b000, a5, 6'b000000, l2, 16'hBEEF};
    endfunction

    task automatic set_start(input logic val);
        if (cur_sel) start2 = val;
        else         start1 = val;
    endtask

    // abort_at > 0 applies rst right after that many transfers; poke re-pulses
    // start while busy and overwrites register 5 once it has been captured.
    task automatic run_dump(input bit sel, input bit rnd, input int abort_at, input bit poke);
        logic [31:0] exp_d [$];
        logic [6:0]  exp_t [$];
        logic        exp_l [$];
        logic [31:0] word;
        logic [31:0] held_d;
        logic [6:0]  held_t;
        logic        held_l;
        bit          stalled;
        bit          got_done;
        bit          written;
        bit          bad_after;
        int          first;
        int          nw;
        int          last_xfer;
        int          done_cyc;
        logic        rdy;

        cur_sel = sel;
        first = sel ? 31 : 1;
        for (int a = first; a <= 31; a++) begin
            nw = (a >= 24) ? 4 : 1;
            for (int l = 0; l < nw; l++) begin
                word = rf[a][32*l +: 32];
                exp_d.push_back(word);
                exp_t.push_back({a[4:0], l[1:0]});
                exp_l.push_back((a == 31) && (l == nw - 1));
            end
        end
        n_obs = 0;
        stalled = 1'b0;
        got_done = 1'b0;
        written = 1'b0;
        last_xfer = -10;
        done_cyc = -1;
        out_ready = 1'b1;

        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("latency_read_busy", bz, 1);
        check("latency_read_valid", v, 0);
        check("latency_read_addr", ra, first);
        tick();
        check("latency_first_valid", v, 1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stalled) begin
                check("stall_hold_data", d, held_d);
                check("stall_hold_tag", t, held_t);
                check("stall_hold_last", lst, held_l);
            end
            if (poke) set_start((n_obs < 20) && (cyc % 3 == 1));
            if (poke && !written && v && (t[6:2] == 5'd6)) begin
                rf[5] = {4{32'hDEAD_0005}};
                written = 1'b1;
            end
            if (dn) begin
                got_done = 1'b1;
                done_cyc = cyc;
                check("done_busy_low", bz, 0);
                check("done_valid_low", v, 0);
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (v && rdy) begin
                if (n_obs < exp_d.size()) begin
                    check("word_data", d, exp_d[n_obs]);
                    check("word_tag", t, exp_t[n_obs]);
                    check("word_last", lst, exp_l[n_obs]);
                    obs_d[n_obs] = d;
                    obs_t[n_obs] = t;
                end else begin
                    check("extra_word", n_obs, exp_d.size() - 1);
                end
                n_obs++;
                last_xfer = cyc;
                if (abort_at > 0 && n_obs == abort_at) begin
                    tick();
                    rst = 1'b1;
                    out_ready = 1'b1;
                    tick();
                    rst = 1'b0;
                    check("abort_valid", v, 0);
                    check("abort_busy", bz, 0);
                    check("abort_tag", t, 0);
                    bad_after = 1'b0;
                    for (int k = 0; k < 15; k++) begin
                        if (dn || bz || v) bad_after = 1'b1;
                        tick();
                    end
                    check("abort_quiet", bad_after, 0);
                    return;
                end
            end
            stalled = v && !rdy;
            held_d = d;
            held_t = t;
            held_l = lst;
            tick();
        end

        out_ready = 1'b1;
        set_start(1'b0);
        check("done_seen", got_done, 1);
        check("word_count", n_obs, exp_d.size());
        check("done_after_last", done_cyc, last_xfer + 1);
        tick();
        check("done_once", dn, 0);
        check("idle_busy", bz, 0);
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            for (int l = 0; l < 4; l++) begin
                rf[a][32*l +: 32] = init_word(a, l);
            end
        end
        rf[24] = 128'h44444444_33333333_22222222_11111111;

        // Reset held together with start: reset must win.
        rst = 1'b1;
        start1 = 1'b1;
        start2 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_valid", valid1, 0);
        check("rst_last", last1, 0);
        check("rst_addr", rf_addr1, 0);
        check("rst_data", data1, 0);
        check("rst_tag", tag1, 0);
        tick();
        check("rst_over_start", busy1, 0);
        check("rst_over_start2", busy2, 0);

        // Full default dump with the sink always ready.
        run_dump(1'b0, 1'b0, 0, 1'b0);
        check("count_55", n_obs, 55);
        check("first_tag", obs_t[0], {5'd1, 2'd0});
        check("r24_w0", obs_d[23], 32'h11111111);
        check("r24_w1", obs_d[24], 32'h22222222);
        check("r24_w2", obs_d[25], 32'h33333333);
        check("r24_w3", obs_d[26], 32'h44444444);
        check("r24_t0", obs_t[23], {5'd24, 2'd0});
        check("r24_t3", obs_t[26], {5'd24, 2'd3});
        check("last_tag", obs_t[54], {5'd31, 2'd3});

        // Same dump with a randomly stalling sink.
        run_dump(1'b0, 1'b1, 0, 1'b0);
        check("rnd_count", n_obs, 55);

        // Single vector register instance.
        run_dump(1'b1, 1'b1, 0, 1'b0);
        check("single_count", n_obs, 4);
        check("single_first_tag", obs_t[0], {5'd31, 2'd0});

        // Abort after 10 transfers, then a fresh full dump.
        run_dump(1'b0, 1'b0, 10, 1'b0);
        check("abort_count", n_obs, 10);
        run_dump(1'b0, 1'b0, 0, 1'b0);
        check("post_abort_count", n_obs, 55);
        check("post_abort_first", obs_t[0], {5'd1, 2'd0});

        // Restart attempts while busy, and register 5 rewritten after its capture.
        run_dump(1'b0, 1'b1, 0, 1'b1);
        check("poke_count", n_obs, 55);
        check("poke_r5_tag", obs_t[4], {5'd5, 2'd0});
        check("poke_r5_data", obs_d[4], 32'h0500BEEF);
        check("poke_r5_written", rf[5], {4{32'hDEAD_0005}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
